// File: rtl/scan_display_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment display controller.
// Segment width, blank pattern and digit-off level are common to all files.
package scan_display_ctrl_pkg;
    localparam int                SEG_W   = 7;
    localparam int                BCD_W   = 4;
    localparam logic [SEG_W-1:0]  SEG_OFF = 7'b0000000;
    localparam logic              DIG_OFF = 1'b1;
endpackage

// File: rtl/scan_display_ctrl_display7.sv
// BCD to 7-segment decoder, active-high, bit0=a .. bit6=g.
// Codes above 9 decode to all segments off.
import scan_display_ctrl_pkg::*;

module display7 (
    input  logic [BCD_W-1:0] A,
    output logic [SEG_W-1:0] Y
);

    // Pure lookup of the segment pattern for one BCD digit
    always_comb begin
        case (A)
            4'd0:    Y = 7'b0111111;
            4'd1:    Y = 7'b0000110;
            4'd2:    Y = 7'b1011011;
            4'd3:    Y = 7'b1001111;
            4'd4:    Y = 7'b1100110;
            4'd5:    Y = 7'b1101101;
            4'd6:    Y = 7'b1111101;
            4'd7:    Y = 7'b0000111;
            4'd8:    Y = 7'b1111111;
            4'd9:    Y = 7'b1101111;
            default: Y = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed common-cathode 7-segment controller with a double-buffered
// display value that only changes at frame boundaries.
import scan_display_ctrl_pkg::*;

module scan_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        blank_lz,
    output logic [SEG_W-1:0]            seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       digit_sel,
    output logic                        frame_done
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [PRE_W-1:0]              pre_r;
    logic [IDX_W-1:0]              idx_r;
    logic [BCD_W*NUM_DIGITS-1:0]   pend_data_r;
    logic [NUM_DIGITS-1:0]         pend_dp_r;
    logic                          pend_r;
    logic [BCD_W*NUM_DIGITS-1:0]   disp_data_r;
    logic [NUM_DIGITS-1:0]         disp_dp_r;
    logic                          boundary_r;

    logic                          tick_s;
    logic                          last_s;
    logic                          boundary_s;
    logic [BCD_W-1:0]              nibble_s;
    logic [SEG_W-1:0]              dec_s;
    logic                          zero_above_s;
    logic                          blank_s;
    logic [NUM_DIGITS-1:0]         sel_s;

    assign tick_s     = (pre_r == PRE_W'(SCAN_DIV - 1));
    assign last_s     = (idx_r == IDX_W'(NUM_DIGITS - 1));
    assign boundary_s = tick_s && last_s;

    // Prescaler and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
            idx_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
            idx_r <= last_s ? '0 : idx_r + IDX_W'(1);
        end else begin
            pre_r <= pre_r + PRE_W'(1);
            idx_r <= idx_r;
        end
    end

    // Pending/display double buffer; a load in the boundary cycle bypasses pending
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data_r <= '0;
            pend_dp_r   <= '0;
            pend_r      <= 1'b0;
            disp_data_r <= '0;
            disp_dp_r   <= '0;
            boundary_r  <= 1'b0;
        end else begin
            boundary_r <= boundary_s;
            if (boundary_s) begin
                pend_r <= 1'b0;
                if (load) begin
                    disp_data_r <= data_in;
                    disp_dp_r   <= dp_in;
                end else if (pend_r) begin
                    disp_data_r <= pend_data_r;
                    disp_dp_r   <= pend_dp_r;
                end else begin
                    disp_data_r <= disp_data_r;
                    disp_dp_r   <= disp_dp_r;
                end
            end else if (load) begin
                pend_data_r <= data_in;
                pend_dp_r   <= dp_in;
                pend_r      <= 1'b1;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    assign nibble_s = disp_data_r[BCD_W*int'(idx_r) +: BCD_W];

    display7 u_display7 (
        .A (nibble_s),
        .Y (dec_s)
    );

    // Leading-zero detection for the current digit and its active-low select
    always_comb begin
        zero_above_s = 1'b1;
        sel_s        = {NUM_DIGITS{DIG_OFF}};
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_r) && disp_data_r[BCD_W*j +: BCD_W] != 4'd0) begin
                zero_above_s = 1'b0;
            end else begin
                zero_above_s = zero_above_s;
            end
        end
        sel_s[idx_r] = ~DIG_OFF;
        blank_s      = blank_lz && (idx_r != '0) && zero_above_s;
    end

    // Registered pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= 1'b0;
            digit_sel  <= {NUM_DIGITS{DIG_OFF}};
            frame_done <= 1'b0;
        end else begin
            seg        <= blank_s ? SEG_OFF : dec_s;
            dp         <= disp_dp_r[idx_r];
            digit_sel  <= sel_s;
            frame_done <= boundary_r;
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed self-checking bench for scan_display_ctrl with SCAN_DIV=4, NUM_DIGITS=4.
module tb_scan_display_ctrl;

    localparam logic [6:0] S0  = 7'b0111111;
    localparam logic [6:0] S1  = 7'b0000110;
    localparam logic [6:0] S2  = 7'b1011011;
    localparam logic [6:0] S3  = 7'b1001111;
    localparam logic [6:0] S4  = 7'b1100110;
    localparam logic [6:0] S5  = 7'b1101101;
    localparam logic [6:0] S6  = 7'b1111101;
    localparam logic [6:0] S7  = 7'b0000111;
    localparam logic [6:0] S8  = 7'b1111111;
    localparam logic [6:0] S9  = 7'b1101111;
    localparam logic [6:0] SOF = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [3:0] sel_tab [4];

    scan_display_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        sel_tab[0] = 4'b1110;
        sel_tab[1] = 4'b1101;
        sel_tab[2] = 4'b1011;
        sel_tab[3] = 4'b0111;
        rst = 1'b1; load = 1'b0; data_in = 16'h0000; dp_in = 4'b0000; blank_lz = 1'b0;
        go(3);
        check("rst_sel", digit_sel, 4'b1111);
        check("rst_seg", seg, SOF);
        check("rst_dp", dp, 1'b0);
        check("rst_fd", frame_done, 1'b0);

        // Idle scan after reset release: 4 cycles per digit, all zeros
        rst = 1'b0; cyc = 0;
        for (int c = 0; c < 16; c++) begin
            go(c + 1);
            check("idle_sel", digit_sel, sel_tab[c / 4]);
            check("idle_seg", seg, S0);
            check("idle_fd", frame_done, 1'b0);
        end
        go(17);
        check("fd_first", frame_done, 1'b1);
        check("fd_sel", digit_sel, 4'b1110);
        go(18);
        check("fd_pulse", frame_done, 1'b0);

        // Mid-frame load of 1234 is held until the boundary
        go(22);
        load = 1'b1; data_in = 16'h1234;
        go(23);
        load = 1'b0;
        go(24);
        check("hold_sel", digit_sel, 4'b1101);
        check("hold_seg", seg, S0);
        go(33);
        check("l1_fd", frame_done, 1'b1);
        check("l1_d0", seg, S4);
        go(37); check("l1_d1", seg, S3);
        go(41); check("l1_d2", seg, S2);
        go(45);
        check("l1_d3", seg, S1);
        check("l1_sel3", digit_sel, 4'b0111);

        // Two loads in one frame: last wins
        go(50);
        load = 1'b1; data_in = 16'h1111;
        go(51);
        load = 1'b0;
        go(54);
        load = 1'b1; data_in = 16'h9876;
        go(55);
        load = 1'b0;
        go(57); check("l2_old_d2", seg, S2);
        go(65);
        check("l2_fd", frame_done, 1'b1);
        check("l2_d0", seg, S6);
        go(69); check("l2_d1", seg, S7);
        go(73); check("l2_d2", seg, S8);
        go(77); check("l2_d3", seg, S9);

        // Leading-zero blanking, dp still driven on a blanked digit
        go(78);
        load = 1'b1; data_in = 16'h0050; dp_in = 4'b0100; blank_lz = 1'b1;
        go(79);
        load = 1'b0; dp_in = 4'b0000;
        go(81); check("lz_d0", seg, S0);
        go(85);
        check("lz_d1", seg, S5);
        check("lz_d1_dp", dp, 1'b0);
        go(89);
        check("lz_d2", seg, SOF);
        check("lz_d2_dp", dp, 1'b1);
        go(93);
        check("lz_d3", seg, SOF);
        blank_lz = 1'b0;
        go(94); check("nolz_d3", seg, S0);
        go(105);
        check("nolz_d2", seg, S0);
        check("nolz_d2_dp", dp, 1'b1);

        // Load exactly in the boundary cycle, with an invalid nibble on digit 1
        go(111);
        load = 1'b1; data_in = 16'h00A7;
        go(112);
        load = 1'b0;
        go(113);
        check("bnd_fd", frame_done, 1'b1);
        check("bnd_d0", seg, S7);
        go(117);
        check("bnd_d1_inv", seg, SOF);
        check("bnd_sel1", digit_sel, 4'b1101);
        go(121); check("bnd_d2", seg, S0);

        // Reset in the middle of digit 2 with pending data
        load = 1'b1; data_in = 16'h5555;
        go(122);
        load = 1'b0; rst = 1'b1;
        go(123);
        check("mrst_sel", digit_sel, 4'b1111);
        check("mrst_seg", seg, SOF);
        check("mrst_fd", frame_done, 1'b0);
        rst = 1'b0; cyc = 0;
        go(1);
        check("mrst_r1_sel", digit_sel, 4'b1110);
        check("mrst_r1_seg", seg, S0);
        go(17);
        check("mrst_fd2", frame_done, 1'b1);
        for (int d = 0; d < 4; d++) begin
            go(17 + 4 * d);
            check("mrst_sel_f", digit_sel, sel_tab[d]);
            check("mrst_seg_f", seg, S0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
